// File: rtl/temp_bcd_pkg.sv
// Shared definitions for the ADT7420 temperature-to-BCD formatter.
// Holds the conversion FSM state type, datapath widths, iteration counts,
// and a helper that builds the fractional-digit keep mask.
package temp_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int TEMP_W     = 13;
   localparam int INT_W      = 9;
   localparam int FRAC_W     = 14;
   localparam int INT_ITERS  = 9;
   localparam int FRAC_ITERS = 14;
   localparam int FRAC_SCALE = 625;

   localparam int INT_DIGITS  = 3;
   localparam int FRAC_DIGMAX = 4;

   // Keeps the top 'digits' BCD digits of the 4-digit fraction, zeroes the rest.
   function automatic logic [15:0] frac_digit_mask(input int digits);
      logic [15:0] m;
      m = '0;
      for (int d = 0; d < FRAC_DIGMAX; d++) begin
         if (d < digits) m[15-4*d -: 4] = 4'hF;
      end
      return m;
   endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble iteration: every BCD digit >= 5 gets +3,
// then the whole digit vector shifts left by one with bit_in entering at bit 0.
// Ports:
//   bcd_in  [4*DIGITS-1:0]  current BCD digits
//   bit_in                  next binary bit (MSB-first)
//   bcd_out [4*DIGITS-1:0]  digits after correction and shift
module bcd_dd_step #(
   parameter int DIGITS = 3
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                bit_in,
   output logic [4*DIGITS-1:0] bcd_out
);

   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd_in;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
      end
   end

   assign bcd_out = {adj[4*DIGITS-2:0], bit_in};

   // The top bit shifted out is always 0 when the value fits in DIGITS digits.
   logic unused_carry;
   assign unused_carry = adj[4*DIGITS-1];

endmodule

// File: rtl/temp_bcd_formatter.sv
// Converts ADT7420 temperature words (13-bit two's complement in [15:3],
// 1/16 degC per LSB) to sign-magnitude BCD with a multi-cycle double-dabble.
// Fixed latency of 16 cycles from acceptance to bcd_valid; results hold
// until the next conversion completes.
//
// Optional feature macro: TEMP_BCD_OVERRUN_EN adds a sticky 'overrun' output
// set by any temp_valid that arrives while busy.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   temp_valid   one-cycle strobe, temp_raw valid
//   temp_raw     ADT7420 register word, [2:0] ignored
//   busy         conversion in flight (PREP/CONV/DONE)
//   bcd_valid    one-cycle pulse with new digits
//   sign         1 = negative
//   int_bcd      hundreds/tens/ones
//   frac_bcd     tenths..ten-thousandths, FRAC_DIGITS kept
//   overrun      sticky drop flag (TEMP_BCD_OVERRUN_EN only)
//
// state | meaning
// IDLE  | waiting for temp_valid, captures temp_raw
// PREP  | derive sign/magnitude/int/frac binaries, clear shifters
// CONV  | 14 double-dabble iterations (integer stops after 9)
// DONE  | publish digits, pulse bcd_valid
module temp_bcd_formatter
   import temp_bcd_pkg::*;
#(
   parameter int FRAC_DIGITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        temp_valid,
   input  logic [15:0] temp_raw,
   output logic        busy,
   output logic        bcd_valid,
   output logic        sign,
   output logic [11:0] int_bcd,
   output logic [15:0] frac_bcd
`ifdef TEMP_BCD_OVERRUN_EN
   ,
   output logic        overrun
`endif
);

   localparam logic [15:0] FRAC_MASK = frac_digit_mask(FRAC_DIGITS);

   state_t state, state_nx;

   logic [TEMP_W-1:0]      t_cap;
   logic                   sign_r;
   logic [INT_W-1:0]       int_bin;
   logic [FRAC_W-1:0]      frac_bin;
   logic [4*INT_DIGITS-1:0] int_sr, int_nx;
   logic [4*FRAC_DIGMAX-1:0] frac_sr, frac_nx;
   logic [3:0]             iter;

   logic [TEMP_W:0]        t_ext;
   logic [TEMP_W:0]        mag;
   logic [FRAC_W-1:0]      frac_scaled;

   logic unused_raw_bits;
   logic unused_mag_msb;
   assign unused_raw_bits = ^temp_raw[2:0];

   // -4096 negates to 4096, which still fits in the 14-bit magnitude.
   assign t_ext       = {t_cap[TEMP_W-1], t_cap};
   assign mag         = t_cap[TEMP_W-1] ? (~t_ext + 14'd1) : t_ext;
   assign frac_scaled = 14'(mag[3:0]) * 14'(FRAC_SCALE);
   assign unused_mag_msb = mag[TEMP_W];

   bcd_dd_step #(.DIGITS(INT_DIGITS)) u_int_step (
      .bcd_in  (int_sr),
      .bit_in  (int_bin[INT_W-1]),
      .bcd_out (int_nx)
   );

   bcd_dd_step #(.DIGITS(FRAC_DIGMAX)) u_frac_step (
      .bcd_in  (frac_sr),
      .bit_in  (frac_bin[FRAC_W-1]),
      .bcd_out (frac_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (temp_valid) state_nx = PREP;
         PREP:    state_nx = CONV;
         CONV:    if (iter == 4'(FRAC_ITERS - 1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_cap     <= '0;
         sign_r    <= 1'b0;
         int_bin   <= '0;
         frac_bin  <= '0;
         int_sr    <= '0;
         frac_sr   <= '0;
         iter      <= '0;
         bcd_valid <= 1'b0;
         sign      <= 1'b0;
         int_bcd   <= '0;
         frac_bcd  <= '0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (temp_valid) t_cap <= temp_raw[15:3];
            end
            PREP: begin
               sign_r   <= t_cap[TEMP_W-1];
               int_bin  <= mag[12:4];
               frac_bin <= frac_scaled;
               int_sr   <= '0;
               frac_sr  <= '0;
               iter     <= '0;
            end
            CONV: begin
               iter     <= iter + 4'd1;
               frac_sr  <= frac_nx;
               frac_bin <= {frac_bin[FRAC_W-2:0], 1'b0};
               if (iter < 4'(INT_ITERS)) begin
                  int_sr  <= int_nx;
                  int_bin <= {int_bin[INT_W-2:0], 1'b0};
               end
            end
            DONE: begin
               sign      <= sign_r;
               int_bcd   <= int_sr;
               frac_bcd  <= frac_sr & FRAC_MASK;
               bcd_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef TEMP_BCD_OVERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 overrun <= 1'b0;
      else if (temp_valid && busy) overrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_temp_bcd_formatter.sv
module tb_temp_bcd_formatter;

   logic        clk;
   logic        rst_n;
   logic        temp_valid;
   logic [15:0] temp_raw;

   logic        busy, bcd_valid, sign;
   logic [11:0] int_bcd;
   logic [15:0] frac_bcd;
   logic        busy2, bcd_valid2, sign2;
   logic [11:0] int_bcd2;
   logic [15:0] frac_bcd2;
`ifdef TEMP_BCD_OVERRUN_EN
   logic        overrun, overrun2;
`endif

   int tests;
   int failed;

   temp_bcd_formatter #(.FRAC_DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temp_raw(temp_raw),
      .busy(busy), .bcd_valid(bcd_valid), .sign(sign),
      .int_bcd(int_bcd), .frac_bcd(frac_bcd)
`ifdef TEMP_BCD_OVERRUN_EN
      , .overrun(overrun)
`endif
   );

   temp_bcd_formatter #(.FRAC_DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temp_raw(temp_raw),
      .busy(busy2), .bcd_valid(bcd_valid2), .sign(sign2),
      .int_bcd(int_bcd2), .frac_bcd(frac_bcd2)
`ifdef TEMP_BCD_OVERRUN_EN
      , .overrun(overrun2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] raw;
      logic        exp_sign;
      logic [11:0] exp_int;
      logic [15:0] exp_frac4;
      logic [15:0] exp_frac2;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the temperature value, digits by /10 and %10.
   function automatic void model(input logic [15:0] raw, input int digs,
                                 output logic s, output logic [11:0] ib,
                                 output logic [15:0] fb);
      logic signed [12:0] ts;
      int t, m, ip, fr, scale;
      ts = raw[15:3];
      t  = ts;
      m  = (t < 0) ? -t : t;
      ip = m / 16;
      fr = (m % 16) * 625;
      scale = 1;
      for (int i = digs; i < 4; i++) scale = scale * 10;
      fr = (fr / scale) * scale;
      s  = (t < 0);
      ib = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
      fb = {4'(fr / 1000), 4'((fr / 100) % 10), 4'((fr / 10) % 10), 4'(fr % 10)};
   endfunction

   task automatic start(input logic [15:0] raw);
      @(negedge clk);
      temp_valid = 1'b1;
      temp_raw   = raw;
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bcd_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_one(input string tag, input logic [15:0] raw,
                          input logic es, input logic [11:0] ei,
                          input logic [15:0] ef4, input logic [15:0] ef2);
      int lat;
      start(raw);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_result(lat);
      chk({tag, " latency"}, 32'(lat), 32'd16);
      chk({tag, " sign"}, 32'(sign), 32'(es));
      chk({tag, " int_bcd"}, 32'(int_bcd), 32'(ei));
      chk({tag, " frac_bcd"}, 32'(frac_bcd), 32'(ef4));
      chk({tag, " frac_bcd2"}, 32'(frac_bcd2), 32'(ef2));
      chk({tag, " valid2"}, 32'(bcd_valid2), 32'd1);
      @(posedge clk);
      #1;
      chk({tag, " pulse width"}, 32'(bcd_valid), 32'd0);
      chk({tag, " busy done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic        ms;
      logic [11:0] mi;
      logic [15:0] mf4, mf2;
      logic [15:0] r;
      int          cnt, first, second, lat;
      logic [11:0] cap_i;
      logic [15:0] cap_f;
      logic        cap_s;

      tests = 0;
      failed = 0;
      temp_valid = 1'b0;
      temp_raw = '0;

      vecs[0] = '{16'h0C80, 1'b0, 12'h025, 16'h0000, 16'h0000};
      vecs[1] = '{16'h0C98, 1'b0, 12'h025, 16'h1875, 16'h1800};
      vecs[2] = '{16'hFFF8, 1'b1, 12'h000, 16'h0625, 16'h0600};
      vecs[3] = '{16'h8000, 1'b1, 12'h256, 16'h0000, 16'h0000};
      vecs[4] = '{16'h7FF8, 1'b0, 12'h255, 16'h9375, 16'h9300};
      vecs[5] = '{16'h0000, 1'b0, 12'h000, 16'h0000, 16'h0000};
      vecs[6] = '{16'hF368, 1'b1, 12'h025, 16'h1875, 16'h1800};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset bcd_valid", 32'(bcd_valid), 32'd0);
      chk("reset sign", 32'(sign), 32'd0);
      chk("reset int_bcd", 32'(int_bcd), 32'd0);
      chk("reset frac_bcd", 32'(frac_bcd), 32'd0);
`ifdef TEMP_BCD_OVERRUN_EN
      chk("reset overrun", 32'(overrun), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         run_one($sformatf("vec%0d", i), vecs[i].raw, vecs[i].exp_sign,
                 vecs[i].exp_int, vecs[i].exp_frac4, vecs[i].exp_frac2);
      end

      for (int i = 0; i < 40; i++) begin
         r = 16'($urandom);
         model(r, 4, ms, mi, mf4);
         model(r, 2, ms, mi, mf2);
         run_one($sformatf("rand%0d(%h)", i, r), r, ms, mi, mf4, mf2);
      end

      // Sample dropped mid-conversion: first result must come out untouched.
      start(16'h0C98);
      repeat (4) @(posedge clk);
      @(negedge clk);
      temp_valid = 1'b1;
      temp_raw   = 16'h0000;
      @(posedge clk);
      #1;
      temp_valid = 1'b0;
      cnt = 0;
      first = 0;
      cap_s = 1'b0;
      cap_i = '0;
      cap_f = '0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bcd_valid) begin
            cnt++;
            if (first == 0) begin
               first = k;
               cap_s = sign;
               cap_i = int_bcd;
               cap_f = frac_bcd;
            end
         end
      end
      chk("drop pulses", 32'(cnt), 32'd1);
      chk("drop latency", 32'(first), 32'd11);
      chk("drop sign", 32'(cap_s), 32'd0);
      chk("drop int_bcd", 32'(cap_i), 32'h025);
      chk("drop frac_bcd", 32'(cap_f), 32'h1875);
      chk("drop hold frac", 32'(frac_bcd), 32'h1875);
`ifdef TEMP_BCD_OVERRUN_EN
      chk("overrun set", 32'(overrun), 32'd1);
      run_one("after overrun", 16'h0C80, 1'b0, 12'h025, 16'h0000, 16'h0000);
      chk("overrun sticky", 32'(overrun), 32'd1);
`endif

      // temp_valid held high: DONE must not accept, next acceptance at E16+1.
      @(negedge clk);
      temp_valid = 1'b1;
      temp_raw   = 16'h0C80;
      cnt = 0;
      first = 0;
      second = 0;
      for (int k = 0; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 20) temp_valid = 1'b0;
         if (bcd_valid) begin
            cnt++;
            if (first == 0) first = k;
            else if (second == 0) second = k;
         end
      end
      chk("thru pulses", 32'(cnt), 32'd2);
      chk("thru first", 32'(first), 32'd16);
      chk("thru second", 32'(second), 32'd33);

      // Put non-zero sign/frac on the outputs so the reset clear is visible.
      run_one("pre reset", 16'hF368, 1'b1, 12'h025, 16'h1875, 16'h1800);

      start(16'h0C98);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst sign", 32'(sign), 32'd0);
      chk("rst int_bcd", 32'(int_bcd), 32'd0);
      chk("rst frac_bcd", 32'(frac_bcd), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (bcd_valid) cnt++;
      end
      chk("rst no pulse", 32'(cnt), 32'd0);
      chk("rst busy after", 32'(busy), 32'd0);
      chk("rst int after", 32'(int_bcd), 32'd0);
      chk("rst frac after", 32'(frac_bcd), 32'd0);
`ifdef TEMP_BCD_OVERRUN_EN
      chk("rst overrun", 32'(overrun), 32'd0);
`endif
      start(16'h0C80);
      wait_result(lat);
      chk("post rst latency", 32'(lat), 32'd16);
      chk("post rst int", 32'(int_bcd), 32'h025);
      chk("post rst frac", 32'(frac_bcd), 32'h0000);
      chk("post rst sign", 32'(sign), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
